// File: rtl/cross_bar_pkg.sv
// Shared types and default sizes for the cross bar.
// Holds the master index type, the read/write command encoding and the
// arbiter state encoding used by the per-slave arbitration stage.
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int RD_OUTST = 4;

  typedef logic [ADDR_W-1:0]           addr_t;
  typedef logic [DATA_W-1:0]           data_t;
  typedef logic [$clog2(MASTER_N)-1:0] mst_idx_t;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cross_bar_id_fifo.sv
// Outstanding-read ID FIFO: remembers which master issued each read so
// in-order slave responses can be routed back.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push, din      write din at the tail (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   head           current head entry
//   full, empty    occupancy flags
module cross_bar_id_fifo
  import cross_bar_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cross_bar_slave_arb.sv
// Per-slave arbitration stage of the cross bar.
// Picks one requesting master round-robin, forwards its request to the
// slave, returns the slave ack to that master, and routes in-order read
// responses back through an outstanding-read ID FIFO.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m_req_i/m_addr_i/m_cmd_i/m_wdata_i  per-master request (flattened)
//   m_ack_o                        ack to granted master, one-hot or zero
//   m_resp_o, m_rdata_o            read response, one-hot valid + shared data
//   s_req_o/s_addr_o/s_cmd_o/s_wdata_o  request to slave
//   s_ack_i                        slave accepted the request
//   s_resp_i, s_rdata_i            in-order read response from slave
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no grant held; pick next eligible master round-robin
// ST_BUSY | master gnt_q owns the slave port until ack or withdrawal
module cross_bar_slave_arb
  import cross_bar_pkg::*;
#(
  parameter int MASTER_N = cross_bar_pkg::MASTER_N,
  parameter int ADDR_W   = cross_bar_pkg::ADDR_W,
  parameter int DATA_W   = cross_bar_pkg::DATA_W,
  parameter int RD_OUTST = cross_bar_pkg::RD_OUTST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MASTER_N-1:0]        m_req_i,
  input  logic [MASTER_N*ADDR_W-1:0] m_addr_i,
  input  logic [MASTER_N-1:0]        m_cmd_i,
  input  logic [MASTER_N*DATA_W-1:0] m_wdata_i,
  output logic [MASTER_N-1:0]        m_ack_o,
  output logic [MASTER_N-1:0]        m_resp_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       s_req_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic                       s_cmd_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  input  logic                       s_ack_i,
  input  logic                       s_resp_i,
  input  logic [DATA_W-1:0]          s_rdata_i
);

  localparam int IDX_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t          state_q, state_d;
  idx_t                gnt_q, gnt_d;
  idx_t                rr_q, rr_d;
  idx_t                pick;
  logic [MASTER_N-1:0] elig;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  idx_t                fifo_head;

  // A read needs a free FIFO slot; writes never wait on the FIFO.
  assign elig = m_req_i & (m_cmd_i | {MASTER_N{~fifo_full}});

  always_comb begin
    int   c;
    logic found;
    pick  = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < MASTER_N; k++) begin
      c = (int'(rr_q) + k) % MASTER_N;
      if (!found && elig[idx_t'(c)]) begin
        pick  = idx_t'(c);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    fifo_push = 1'b0;
    s_req_o   = 1'b0;
    s_addr_o  = '0;
    s_cmd_o   = 1'b0;
    s_wdata_o = '0;
    m_ack_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          gnt_d   = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < MASTER_N; i++) begin
          if (gnt_q == idx_t'(i)) begin
            s_req_o    = m_req_i[i];
            s_addr_o   = m_addr_i[i*ADDR_W +: ADDR_W];
            s_cmd_o    = m_cmd_i[i];
            s_wdata_o  = m_wdata_i[i*DATA_W +: DATA_W];
            m_ack_o[i] = s_ack_i;
          end
        end
        if (s_ack_i) begin
          fifo_push = (s_cmd_o == CMD_RD);
          rr_d      = (gnt_q == idx_t'(MASTER_N-1)) ? '0 : gnt_q + 1'b1;
          state_d   = ST_IDLE;
        end else if (!s_req_o) begin
          // Master withdrew: drop the grant without moving the pointer.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are forced quiet while reset is held, not just after it.
    if (rst) begin
      fifo_push = 1'b0;
      s_req_o   = 1'b0;
      s_addr_o  = '0;
      s_cmd_o   = 1'b0;
      s_wdata_o = '0;
      m_ack_o   = '0;
    end
  end

  // Responses with no outstanding ID are dropped.
  always_comb begin
    fifo_pop  = 1'b0;
    m_resp_o  = '0;
    m_rdata_o = '0;
    if (s_resp_i && !fifo_empty && !rst) begin
      fifo_pop  = 1'b1;
      m_rdata_o = s_rdata_i;
      for (int i = 0; i < MASTER_N; i++) begin
        if (fifo_head == idx_t'(i)) m_resp_o[i] = 1'b1;
      end
    end
  end

  cross_bar_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (RD_OUTST)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (gnt_q),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_cross_bar_slave_arb.sv
// Bench for cross_bar_slave_arb: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level model that
// tracks the current owner, the round-robin pointer and a queue of
// outstanding read IDs.
module tb_cross_bar_slave_arb;

  localparam int MN = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [MN-1:0]  m_req, m_cmd, m_ack, m_resp;
  logic [MN*AW-1:0] m_addr;
  logic [MN*DW-1:0] m_wdata;
  logic [DW-1:0]  m_rdata;
  logic           s_req, s_cmd, s_ack, s_resp;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata, s_rdata;

  cross_bar_slave_arb dut (
    .clk       (clk),
    .rst       (rst),
    .m_req_i   (m_req),
    .m_addr_i  (m_addr),
    .m_cmd_i   (m_cmd),
    .m_wdata_i (m_wdata),
    .m_ack_o   (m_ack),
    .m_resp_o  (m_resp),
    .m_rdata_o (m_rdata),
    .s_req_o   (s_req),
    .s_addr_o  (s_addr),
    .s_cmd_o   (s_cmd),
    .s_wdata_o (s_wdata),
    .s_ack_i   (s_ack),
    .s_resp_i  (s_resp),
    .s_rdata_i (s_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: owner = -1 when nobody holds the slave port
  int owner = -1;
  int rr    = 0;
  int idq[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are already applied; compare mid-cycle, then advance the model.
  task automatic run_cycle();
    logic [MN-1:0] e_ack, e_resp;
    logic          e_sreq, e_scmd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    bit            do_pop, full;
    #3;
    e_ack = '0; e_resp = '0; e_sreq = 0; e_scmd = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; do_pop = 0;
    if (!rst) begin
      if (owner >= 0) begin
        e_sreq       = m_req[owner];
        e_scmd       = m_cmd[owner];
        e_addr       = m_addr[owner*AW +: AW];
        e_wdata      = m_wdata[owner*DW +: DW];
        e_ack[owner] = s_ack;
      end
      do_pop = s_resp && (idq.size() > 0);
      if (do_pop) begin
        e_resp[idq[0]] = 1'b1;
        e_rdata        = s_rdata;
      end
    end
    check("m_ack",   64'(m_ack),   64'(e_ack));
    check("m_resp",  64'(m_resp),  64'(e_resp));
    check("s_req",   64'(s_req),   64'(e_sreq));
    check("s_cmd",   64'(s_cmd),   64'(e_scmd));
    check("s_addr",  64'(s_addr),  64'(e_addr));
    check("s_wdata", 64'(s_wdata), 64'(e_wdata));
    if (rst || !s_resp || do_pop) check("m_rdata", 64'(m_rdata), 64'(e_rdata));

    if (rst) begin
      owner = -1;
      rr    = 0;
      idq.delete();
    end else begin
      full = (idq.size() == RO);
      if (do_pop) void'(idq.pop_front());
      if (owner >= 0) begin
        if (s_ack) begin
          if (!m_cmd[owner]) idq.push_back(owner);
          rr    = (owner + 1) % MN;
          owner = -1;
        end else if (!m_req[owner]) begin
          owner = -1;
        end
      end else begin
        for (int k = 0; k < MN; k++) begin
          int c;
          c = (rr + k) % MN;
          if (owner < 0 && m_req[c] && (m_cmd[c] || !full)) owner = c;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic [MN-1:0] req, logic [MN-1:0] cmd,
                       logic ack, logic resp, logic [DW-1:0] rdata);
    rst     = r;
    m_req   = req;
    m_cmd   = cmd;
    s_ack   = ack;
    s_resp  = resp;
    s_rdata = rdata;
    run_cycle();
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_cmd = '0; s_ack = 0; s_resp = 0; s_rdata = '0;
    for (int i = 0; i < MN; i++) begin
      m_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i * 16);
      m_wdata[i*DW +: DW] = 32'h5555_0000 + 32'(i);
    end
    m_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;

    // reset
    drive(1, 4'h0, 4'h0, 0, 0, '0);
    drive(1, 4'hF, 4'hF, 1, 1, 32'h1234_5678);
    // single write from master 2
    drive(0, 4'b0100, 4'b0100, 1, 0, '0);
    drive(0, 4'b0100, 4'b0100, 1, 0, '0);
    drive(0, 4'b0000, 4'b0000, 0, 0, '0);
    // fairness: everybody writes
    for (int n = 0; n < 10; n++) drive(0, 4'hF, 4'hF, 1, 0, '0);
    drive(0, 4'h0, 4'h0, 0, 0, '0);
    // read routing: master 1 then master 3
    drive(0, 4'b0010, 4'b0000, 1, 0, '0);
    drive(0, 4'b0010, 4'b0000, 1, 0, '0);
    drive(0, 4'b1000, 4'b0000, 1, 0, '0);
    drive(0, 4'b1000, 4'b0000, 1, 0, '0);
    drive(0, 4'b0000, 4'b0000, 0, 1, 32'hA5A5_0001);
    drive(0, 4'b0000, 4'b0000, 0, 1, 32'hA5A5_0003);
    // fill the FIFO with four reads
    for (int m = 0; m < MN; m++) begin
      drive(0, 4'(1 << m), 4'h0, 1, 0, '0);
      drive(0, 4'(1 << m), 4'h0, 1, 0, '0);
    end
    // master 0 read blocked, master 2 write proceeds
    for (int n = 0; n < 4; n++) drive(0, 4'b0101, 4'b0100, 1, 0, '0);
    drive(0, 4'b0001, 4'b0000, 0, 1, 32'hB0B0_0000);
    drive(0, 4'b0001, 4'b0000, 1, 0, '0);
    drive(0, 4'b0001, 4'b0000, 1, 0, '0);
    // drain to two, then push and pop together
    drive(0, 4'b0000, 4'b0000, 0, 1, 32'hB0B0_0001);
    drive(0, 4'b0000, 4'b0000, 0, 1, 32'hB0B0_0002);
    drive(0, 4'b0010, 4'b0000, 0, 0, '0);
    drive(0, 4'b0010, 4'b0000, 1, 1, 32'hC0C0_0001);
    for (int n = 0; n < 3; n++) drive(0, 4'b0000, 4'b0000, 0, 1, 32'hC0C0_0010 + 32'(n));
    // reset in BUSY with two reads outstanding
    drive(0, 4'b0100, 4'b0000, 1, 0, '0);
    drive(0, 4'b0100, 4'b0000, 1, 0, '0);
    drive(0, 4'b1000, 4'b0000, 1, 0, '0);
    drive(0, 4'b1000, 4'b0000, 1, 0, '0);
    drive(0, 4'b0001, 4'b0000, 0, 0, '0);
    drive(1, 4'b0001, 4'b0000, 1, 1, 32'hDDDD_0000);
    drive(0, 4'b0000, 4'b0000, 0, 1, 32'hDDDD_0001);
    drive(0, 4'b0000, 4'b0000, 0, 0, '0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < MN; i++) begin
        m_addr[i*AW +: AW]  = $urandom;
        m_wdata[i*DW +: DW] = $urandom;
      end
      drive(($urandom_range(0, 63) == 0),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 1) == 1),
            $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
